// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver: prescaled scan, BCD decode, active-low outputs.
// Optional LEADING_ZERO_BLANK_EN darkens leading-zero slots (digit 0 always shown).
module seg7_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            tick;

  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic [3:0]      digit_cur;
  logic [3:0]      lz;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // non-BCD shows a dash
    endcase
    return s;
  endfunction

  // Prescaler and scan index
  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    digit_cur = digits[3:0];
    unique case (idx_q)
      2'd0: digit_cur = digits[3:0];
      2'd1: digit_cur = digits[7:4];
      2'd2: digit_cur = digits[11:8];
      2'd3: digit_cur = digits[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A lit decimal point on a slot keeps it and every lower slot visible.
  always_comb begin
    lz    = 4'b0000;
    lz[3] = (digits[15:12] == 4'd0) && !dp_en[3];
    lz[2] = lz[3] && (digits[11:8] == 4'd0) && !dp_en[2];
    lz[1] = lz[2] && (digits[7:4] == 4'd0) && !dp_en[1];
  end
`else
  assign lz = 4'b0000;
`endif

  // Dark on the tick cycle gives one blank clock between digits to avoid ghosting.
  always_comb begin
    an_d  = (tick || blank || lz[idx_q]) ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = decode(digit_cur);
    dp_d  = ~dp_en[idx_q];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      an_q  <= 4'b1111;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_DIV=4: reset, scan order, decode, blank,
// mid-slot reset and leading-zero behaviour.
module tb_seg7_scan;

  logic        clk;
  logic        clr_n;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;
  int ph     = 0;  // edges since reset release

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } scan_vec_t;

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
  } dec_vec_t;

  scan_vec_t scan_tbl[16];
  dec_vec_t  dec_tbl[16];

  seg7_scan #(.SCAN_DIV(4)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .digits (digits),
    .dp_en  (dp_en),
    .blank  (blank),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (ph=%0d)", name, act, exp, ph);
    end
  endtask

  function automatic logic [3:0] model_an(input int p, input logic [15:0] d,
                                          input logic [3:0] de, input logic b);
    int         s;
    logic [3:0] lz;
    s  = (p % 16) / 4;
    lz = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    lz[3] = (d[15:12] == 4'd0) && !de[3];
    lz[2] = lz[3] && (d[11:8] == 4'd0) && !de[2];
    lz[1] = lz[2] && (d[7:4] == 4'd0) && !de[1];
`endif
    if ((p % 4) == 3 || b || lz[s]) return 4'b1111;
    return ~(4'b0001 << s);
  endfunction

  // One edge, checked against the slot model; seg/dp checked on every non-tick edge.
  task automatic step_check(input string tag);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         s;
    s     = (ph % 16) / 4;
    e_an  = model_an(ph, digits, dp_en, blank);
    e_seg = dec_tbl[digits[s*4 +: 4]].seg;
    e_dp  = ~dp_en[s];
    @(posedge clk);
    #1;
    check({tag, "_an"}, {12'h0, an}, {12'h0, e_an});
    if ((ph % 4) != 3) begin
      check({tag, "_seg"}, {9'h0, seg}, {9'h0, e_seg});
      check({tag, "_dp"}, {15'h0, dp}, {15'h0, e_dp});
    end
    ph++;
  endtask

  task automatic advance_to(input int target);
    while ((ph % 16) != target) step_check("adv");
  endtask

  initial begin
    scan_tbl[0]  = '{4'b1110, 7'h19}; scan_tbl[1]  = '{4'b1110, 7'h19};
    scan_tbl[2]  = '{4'b1110, 7'h19}; scan_tbl[3]  = '{4'b1111, 7'h00};
    scan_tbl[4]  = '{4'b1101, 7'h30}; scan_tbl[5]  = '{4'b1101, 7'h30};
    scan_tbl[6]  = '{4'b1101, 7'h30}; scan_tbl[7]  = '{4'b1111, 7'h00};
    scan_tbl[8]  = '{4'b1011, 7'h24}; scan_tbl[9]  = '{4'b1011, 7'h24};
    scan_tbl[10] = '{4'b1011, 7'h24}; scan_tbl[11] = '{4'b1111, 7'h00};
    scan_tbl[12] = '{4'b0111, 7'h79}; scan_tbl[13] = '{4'b0111, 7'h79};
    scan_tbl[14] = '{4'b0111, 7'h79}; scan_tbl[15] = '{4'b1111, 7'h00};

    dec_tbl[0]  = '{4'd0,  7'h40}; dec_tbl[1]  = '{4'd1,  7'h79};
    dec_tbl[2]  = '{4'd2,  7'h24}; dec_tbl[3]  = '{4'd3,  7'h30};
    dec_tbl[4]  = '{4'd4,  7'h19}; dec_tbl[5]  = '{4'd5,  7'h12};
    dec_tbl[6]  = '{4'd6,  7'h02}; dec_tbl[7]  = '{4'd7,  7'h78};
    dec_tbl[8]  = '{4'd8,  7'h00}; dec_tbl[9]  = '{4'd9,  7'h10};
    dec_tbl[10] = '{4'd10, 7'h3F}; dec_tbl[11] = '{4'd11, 7'h3F};
    dec_tbl[12] = '{4'd12, 7'h3F}; dec_tbl[13] = '{4'd13, 7'h3F};
    dec_tbl[14] = '{4'd14, 7'h3F}; dec_tbl[15] = '{4'd15, 7'h3F};

    // Reset held with live digits present
    clr_n  = 1'b0;
    digits = 16'h1234;
    dp_en  = 4'b0000;
    blank  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", {12'h0, an}, 16'h000F);
    check("rst_seg", {9'h0, seg}, 16'h007F);
    check("rst_dp", {15'h0, dp}, 16'h0001);
    clr_n = 1'b1;
    ph    = 0;

    // Scan order after release, first edge lights digit 0
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("scan%0d_an", i), {12'h0, an}, {12'h0, scan_tbl[i].an});
      if (scan_tbl[i].an != 4'b1111)
        check($sformatf("scan%0d_seg", i), {9'h0, seg}, {9'h0, scan_tbl[i].seg});
      check($sformatf("scan%0d_dp", i), {15'h0, dp}, 16'h0001);
      ph++;
    end
    check("scan_wrap_an", {12'h0, model_an(ph, digits, dp_en, blank)}, 16'h000E);

    // Decode of every nibble, all four slots carrying the same value
    for (int i = 0; i < 16; i++) begin
      digits = {4{dec_tbl[i].dig}};
      if ((ph % 4) == 3) begin
        @(posedge clk);
        #1;
        ph++;
      end
      @(posedge clk);
      #1;
      check($sformatf("dec%0d_seg", i), {9'h0, seg}, {9'h0, dec_tbl[i].seg});
      ph++;
    end

    // Non-BCD dash plus decimal point on slot 0
    digits = 16'h00AF;
    dp_en  = 4'b0001;
    repeat (16) step_check("dpen");

    // Blank for 6 clocks starting mid-slot 1
    digits = 16'h1234;
    dp_en  = 4'b0000;
    advance_to(5);
    blank = 1'b1;
    repeat (6) step_check("blank");
    blank = 1'b0;
    step_check("blank_gap");
    step_check("blank_rel");
    check("blank_resume", {12'h0, an}, 16'h0007);
    check("blank_resume_seg", {9'h0, seg}, 16'h0079);

    // Asynchronous reset pulse mid-slot 2
    advance_to(9);
    step_check("pre_rst");
    #1 clr_n = 1'b0;
    #1;
    check("arst_an", {12'h0, an}, 16'h000F);
    check("arst_seg", {9'h0, seg}, 16'h007F);
    check("arst_dp", {15'h0, dp}, 16'h0001);
    @(posedge clk);
    #1;
    check("arst_hold_an", {12'h0, an}, 16'h000F);
    clr_n = 1'b1;
    ph    = 0;
    step_check("post_rst");
    check("post_rst_first", {12'h0, an}, 16'h000E);
    repeat (7) step_check("post_rst");

    // Leading zeros
    advance_to(0);
    digits = 16'h0050;
    repeat (16) step_check("lz");
    dp_en = 4'b0100;
    repeat (16) step_check("lz_dp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream display stage for the decade counters: takes four packed BCD digits (one counter's low nibble per slot) and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Each cycle it decodes the active digit to segments and drives the matching anode.
- A prescaler on the system clock paces the scan.
- Outputs are active-low to match the board.

Parameters:
- SCAN_DIV, 50000: system clocks per digit slot; legal minimum is 2. At 50 MHz the default gives a 1 kHz slot rate.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- digits  in  16  BCD digits; digit k is bits [4k+3:4k]; digit 0 is rightmost.
- dp_en  in  4  decimal point enable per digit, active-high.
- blank  in  1  synchronous display blank, active-high.
- an  out  4  anode selects, active-low, registered.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - prescaler=0, idx=0.
  - an=4'b1111, seg=7'h7F, dp=1.
  - Takes effect immediately, including mid-slot.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick=1 when the count equals SCAN_DIV-1.
- Scan index:
  - idx is 2 bits and advances by 1 on tick.
  - It wraps 3->0, giving the sequence 0,1,2,3,0...
- Anti-ghost gap: on the tick cycle the registered an is 4'b1111 (one dark clock at every digit change).
- All other cycles:
  - an <= ~(4'b0001 << idx), unless blank=1, in which case an <= 4'b1111.
  - seg <= decode(digits[idx]).
  - dp <= ~dp_en[idx].
- Latency: 1 clock. The digit input is sampled live every clock, so a change to the active digit appears on seg at the next edge.
- After reset release:
  - The first edge drives digit 0 (an=1110).
  - Digit k is lit for SCAN_DIV-1 clocks per slot.
- Decode (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Non-BCD values 10..15 show a dash: 3F (only g lit).
- Blank:
  - The prescaler and idx keep running while blanked.
  - seg and dp still update; only the anodes are forced off.
  - Release resumes at whatever slot idx is in, with no re-sync.
- Simultaneous events:
  - blank and tick together: an=1111 (both force dark).
  - Reset dominates everything.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined, slot k (k=3..1) is dark (an=1111) when digit k is 0 and all higher digits are 0. Leading-zero status is computed combinationally from the live digits input.
  - Digit 0 is never suppressed.
  - dp_en[k]=1 overrides suppression for that slot, and therefore for all lower slots as well.
- When undefined, all four digits are always shown, including leading zeros.

Test Plan:
- Reset: hold clr_n=0 with digits=16'h1234, then release.
  - During reset: an=1111, seg=7F, dp=1.
  - First edge after release: an=1110, seg=19.
- Scan with SCAN_DIV=4, digits=16'h1234, dp_en=0.
  - an pattern per slot: 1110 x3, 1111 x1, 1101 x3, 1111, 1011 x3, 1111, 0111 x3, 1111, then repeats.
  - seg=19, 30, 24, 79 in the respective slots; dp stays 1.
- digits=16'h00AF, dp_en=4'b0001.
  - Slot 0: seg=3F, dp=0.
  - Slot 1: seg=3F, dp=1.
  - Slots 2 and 3: seg=40.
- Assert blank=1 for 6 clocks mid-slot 1 (SCAN_DIV=4).
  - an=1111 from the next edge.
  - idx has advanced on release; display resumes in slot 3 with no glitch.
- Pulse clr_n low for 1 clock mid-slot 2.
  - Outputs go to reset values asynchronously.
  - Scan restarts at slot 0 with a fresh SCAN_DIV-1 lit period.
- digits=16'h0050 with LEADING_ZERO_BLANK_EN.
  - Slots 3 and 2: an=1111.
  - Slot 1: an=1101, seg=12.
  - Slot 0: an=1110, seg=40.
  - Without the macro, slots 3 and 2 light with seg=40.
